// File: rtl/cuckoo_lookup.sv
// cuckoo_lookup: read/delete side of a two-table cuckoo hash.
// Latches a key and its two candidate indices, reads table1[idx1] and
// table2[idx2], compares, optionally clears the matching filled bit, and
// returns hit/table/slot with valid/ready handshaking. Keeps saturating
// hit and miss counters.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_key, req_idx1, req_idx2   key and candidate slots
//   req_del                       1 = clear the slot on a hit
//   t1_rd_en/addr, t1_rd_data/full  table1 read port (1-cycle latency)
//   t1_clr_en/addr                table1 filled-bit clear port
//   t2_*                          same for table2
//   rsp_valid/rsp_ready           response handshake
//   rsp_hit, rsp_tbl, rsp_idx     result (tbl/idx are 0 on a miss)
//   hit_cnt, miss_cnt             saturating response statistics
module cuckoo_lookup #(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic [IDX_W-1:0] req_idx1,
  input  logic [IDX_W-1:0] req_idx2,
  input  logic             req_del,
  output logic             t1_rd_en,
  output logic [IDX_W-1:0] t1_rd_addr,
  input  logic [KEY_W-1:0] t1_rd_data,
  input  logic             t1_rd_full,
  output logic             t1_clr_en,
  output logic [IDX_W-1:0] t1_clr_addr,
  output logic             t2_rd_en,
  output logic [IDX_W-1:0] t2_rd_addr,
  input  logic [KEY_W-1:0] t2_rd_data,
  input  logic             t2_rd_full,
  output logic             t2_clr_en,
  output logic [IDX_W-1:0] t2_clr_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic             rsp_tbl,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CMP  = 3'd2,
    S_CLR  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next;

  // Latched request; r_v* record whether each index was in range.
  logic [KEY_W-1:0] r_key;
  logic [IDX_W-1:0] r_idx1;
  logic [IDX_W-1:0] r_idx2;
  logic             r_del;
  logic             r_v1;
  logic             r_v2;

  logic             w_accept;
  logic             w_in1;
  logic             w_in2;
  logic             w_hit1;
  logic             w_hit2;
  logic             w_rsp_fire;

  // Next values of the registered outputs.
  logic             w_t1_rd_en;
  logic [IDX_W-1:0] w_t1_rd_addr;
  logic             w_t2_rd_en;
  logic [IDX_W-1:0] w_t2_rd_addr;
  logic             w_t1_clr_en;
  logic [IDX_W-1:0] w_t1_clr_addr;
  logic             w_t2_clr_en;
  logic [IDX_W-1:0] w_t2_clr_addr;
  logic             w_rsp_hit;
  logic             w_rsp_tbl;
  logic [IDX_W-1:0] w_rsp_idx;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_in1      = (32'(req_idx1) < DEPTH);
  assign w_in2      = (32'(req_idx2) < DEPTH);
  // A table whose index was out of range never matches, whatever stale
  // data its read port still presents.
  assign w_hit1     = r_v1 && t1_rd_full && (t1_rd_data == r_key);
  assign w_hit2     = r_v2 && t2_rd_full && (t2_rd_data == r_key);
  assign w_rsp_fire = rsp_valid && rsp_ready;

  // Next-state and next-output logic.
  always_comb begin
    w_next        = r_state;
    w_t1_rd_en    = 1'b0;
    w_t1_rd_addr  = '0;
    w_t2_rd_en    = 1'b0;
    w_t2_rd_addr  = '0;
    w_t1_clr_en   = 1'b0;
    w_t1_clr_addr = '0;
    w_t2_clr_en   = 1'b0;
    w_t2_clr_addr = '0;
    w_rsp_hit     = rsp_hit;
    w_rsp_tbl     = rsp_tbl;
    w_rsp_idx     = rsp_idx;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next       = S_READ;
          w_t1_rd_en   = w_in1;
          w_t1_rd_addr = w_in1 ? req_idx1 : '0;
          w_t2_rd_en   = w_in2;
          w_t2_rd_addr = w_in2 ? req_idx2 : '0;
        end
      end
      S_READ: w_next = S_CMP;
      S_CMP: begin
        // Table1 wins when both tables hold the key.
        w_rsp_hit = w_hit1 || w_hit2;
        w_rsp_tbl = !w_hit1 && w_hit2;
        w_rsp_idx = w_hit1 ? r_idx1 : (w_hit2 ? r_idx2 : '0);
        if (r_del && (w_hit1 || w_hit2)) begin
          w_next        = S_CLR;
          w_t1_clr_en   = w_hit1;
          w_t1_clr_addr = w_hit1 ? r_idx1 : '0;
          w_t2_clr_en   = !w_hit1 && w_hit2;
          w_t2_clr_addr = (!w_hit1 && w_hit2) ? r_idx2 : '0;
        end else begin
          w_next = S_RESP;
        end
      end
      S_CLR: w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_next    = S_IDLE;
          w_rsp_hit = 1'b0;
          w_rsp_tbl = 1'b0;
          w_rsp_idx = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_key       <= '0;
      r_idx1      <= '0;
      r_idx2      <= '0;
      r_del       <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      req_ready   <= 1'b1;
      t1_rd_en    <= 1'b0;
      t1_rd_addr  <= '0;
      t2_rd_en    <= 1'b0;
      t2_rd_addr  <= '0;
      t1_clr_en   <= 1'b0;
      t1_clr_addr <= '0;
      t2_clr_en   <= 1'b0;
      t2_clr_addr <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_tbl     <= 1'b0;
      rsp_idx     <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      r_state     <= w_next;
      if (w_accept) begin
        r_key  <= req_key;
        r_idx1 <= req_idx1;
        r_idx2 <= req_idx2;
        r_del  <= req_del;
        r_v1   <= w_in1;
        r_v2   <= w_in2;
      end
      req_ready   <= (w_next == S_IDLE);
      t1_rd_en    <= w_t1_rd_en;
      t1_rd_addr  <= w_t1_rd_addr;
      t2_rd_en    <= w_t2_rd_en;
      t2_rd_addr  <= w_t2_rd_addr;
      t1_clr_en   <= w_t1_clr_en;
      t1_clr_addr <= w_t1_clr_addr;
      t2_clr_en   <= w_t2_clr_en;
      t2_clr_addr <= w_t2_clr_addr;
      rsp_valid   <= (w_next == S_RESP);
      rsp_hit     <= w_rsp_hit;
      rsp_tbl     <= w_rsp_tbl;
      rsp_idx     <= w_rsp_idx;
      if (w_rsp_fire) begin
        if (rsp_hit) begin
          if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_W'(1);
        end else begin
          if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Directed bench for cuckoo_lookup with behavioural table memories.
module tb_cuckoo_lookup;

  localparam int unsigned KEY_W = 32;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [KEY_W-1:0] req_key;
  logic [IDX_W-1:0] req_idx1;
  logic [IDX_W-1:0] req_idx2;
  logic             req_del;
  logic             t1_rd_en, t2_rd_en;
  logic [IDX_W-1:0] t1_rd_addr, t2_rd_addr;
  logic [KEY_W-1:0] t1_rd_data, t2_rd_data;
  logic             t1_rd_full, t2_rd_full;
  logic             t1_clr_en, t2_clr_en;
  logic [IDX_W-1:0] t1_clr_addr, t2_clr_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit;
  logic             rsp_tbl;
  logic [IDX_W-1:0] rsp_idx;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  cuckoo_lookup #(.KEY_W(KEY_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_idx1(req_idx1), .req_idx2(req_idx2), .req_del(req_del),
    .t1_rd_en(t1_rd_en), .t1_rd_addr(t1_rd_addr), .t1_rd_data(t1_rd_data),
    .t1_rd_full(t1_rd_full), .t1_clr_en(t1_clr_en), .t1_clr_addr(t1_clr_addr),
    .t2_rd_en(t2_rd_en), .t2_rd_addr(t2_rd_addr), .t2_rd_data(t2_rd_data),
    .t2_rd_full(t2_rd_full), .t2_clr_en(t2_clr_en), .t2_clr_addr(t2_clr_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_tbl(rsp_tbl), .rsp_idx(rsp_idx), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Table memories: written only by the stimulus, read with 1-cycle latency.
  logic [KEY_W-1:0] m1_data [64];
  logic             m1_full [64];
  logic [KEY_W-1:0] m2_data [64];
  logic             m2_full [64];

  int t1_rd_n = 0, t2_rd_n = 0, t1_clr_n = 0, t2_clr_n = 0;
  logic [IDX_W-1:0] t1_clr_last = '0, t2_clr_last = '0;

  always @(posedge clk) begin
    if (t1_rd_en) begin
      t1_rd_data <= m1_data[t1_rd_addr];
      t1_rd_full <= m1_full[t1_rd_addr];
      t1_rd_n    <= t1_rd_n + 1;
    end
    if (t2_rd_en) begin
      t2_rd_data <= m2_data[t2_rd_addr];
      t2_rd_full <= m2_full[t2_rd_addr];
      t2_rd_n    <= t2_rd_n + 1;
    end
    if (t1_clr_en) begin
      t1_clr_n    <= t1_clr_n + 1;
      t1_clr_last <= t1_clr_addr;
    end
    if (t2_clr_en) begin
      t2_clr_n    <= t2_clr_n + 1;
      t2_clr_last <= t2_clr_addr;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 64; i++) begin
      m1_data[i] = '0; m1_full[i] = 1'b0;
      m2_data[i] = '0; m2_full[i] = 1'b0;
    end
  endtask

  // Issue one request and wait for rsp_valid; lat is the cycle index of
  // rsp_valid with the accept cycle counted as 0. Called at posedge+1.
  task automatic send(input logic [KEY_W-1:0] key, input logic [IDX_W-1:0] i1,
                      input logic [IDX_W-1:0] i2, input logic del, output int lat);
    chk("req_ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_key = key; req_idx1 = i1; req_idx2 = i2; req_del = del;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  int lat;
  int c1, c2, r1, r2;

  initial begin
    clear_tables();
    rst = 1'b1; req_valid = 1'b0; req_key = '0; req_idx1 = '0; req_idx2 = '0;
    req_del = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'({req_ready, rsp_valid, t1_rd_en, t2_rd_en, t1_clr_en, t2_clr_en,
                            rsp_hit, rsp_tbl, rsp_idx, hit_cnt, miss_cnt}),
        64'({1'b1, 13'b0, 2'b0, 2'b0}));
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: table1 lookup hit
    m1_data[3] = 32'hDEAD; m1_full[3] = 1'b1;
    send(32'hDEAD, 6'd3, 6'd7, 1'b0, lat);
    chk("t1_lat", 64'(lat), 64'd3);
    chk("t1_rsp", 64'({rsp_valid, rsp_hit, rsp_tbl, rsp_idx}), 64'({3'b110, 6'd3}));
    finish_rsp();
    chk("t1_hit_cnt", 64'(hit_cnt), 64'd1);
    chk("t1_req_ready", 64'(req_ready), 64'd1);

    // 2: delete hit in table2 only
    clear_tables();
    m2_data[7] = 32'hBEEF; m2_full[7] = 1'b1;
    c1 = t1_clr_n; c2 = t2_clr_n;
    send(32'hBEEF, 6'd3, 6'd7, 1'b1, lat);
    chk("t2_lat", 64'(lat), 64'd4);
    chk("t2_rsp", 64'({rsp_hit, rsp_tbl, rsp_idx}), 64'({2'b11, 6'd7}));
    chk("t2_clr_pulses", 64'({t1_clr_n - c1, t2_clr_n - c2}), {32'd0, 32'd1});
    chk("t2_clr_addr", 64'(t2_clr_last), 64'd7);
    finish_rsp();
    chk("t2_hit_cnt", 64'(hit_cnt), 64'd2);

    // 3: delete miss
    c1 = t1_clr_n; c2 = t2_clr_n;
    send(32'h1234, 6'd3, 6'd7, 1'b1, lat);
    chk("miss_lat", 64'(lat), 64'd3);
    chk("miss_rsp", 64'({rsp_hit, rsp_tbl, rsp_idx}), 64'd0);
    chk("miss_no_clr", 64'({t1_clr_n - c1, t2_clr_n - c2}), 64'd0);
    finish_rsp();
    chk("miss_cnt_1", 64'({hit_cnt, miss_cnt}), 64'({2'd2, 2'd1}));

    // 5: hold the response for 5 cycles
    send(32'h9999, 6'd0, 6'd0, 1'b0, lat);
    chk("hold_lat", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", 64'({rsp_valid, rsp_hit, rsp_tbl, rsp_idx, req_ready, hit_cnt, miss_cnt}),
          64'({1'b1, 8'd0, 1'b0, 2'd2, 2'd1}));
    end
    finish_rsp();
    chk("hold_release", 64'({req_ready, rsp_valid, hit_cnt, miss_cnt}), 64'({2'b10, 2'd2, 2'd2}));

    // 4: both tables hold the key at the same index; delete
    clear_tables();
    m1_data[2] = 32'h55; m1_full[2] = 1'b1;
    m2_data[2] = 32'h55; m2_full[2] = 1'b1;
    c1 = t1_clr_n; c2 = t2_clr_n;
    send(32'h55, 6'd2, 6'd2, 1'b1, lat);
    chk("both_lat", 64'(lat), 64'd4);
    chk("both_rsp", 64'({rsp_hit, rsp_tbl, rsp_idx}), 64'({2'b10, 6'd2}));
    chk("both_clr_t1_only", 64'({t1_clr_n - c1, t2_clr_n - c2}), {32'd1, 32'd0});
    chk("both_clr_addr", 64'(t1_clr_last), 64'd2);
    finish_rsp();
    chk("both_hit_cnt", 64'(hit_cnt), 64'd3);

    // Saturation of the 2-bit hit counter
    send(32'h55, 6'd2, 6'd9, 1'b0, lat);
    finish_rsp();
    chk("hit_cnt_sat", 64'({hit_cnt, miss_cnt}), 64'({2'd3, 2'd2}));

    // 6: reset during the CMP cycle of a delete that would hit
    clear_tables();
    m2_data[7] = 32'hBEEF; m2_full[7] = 1'b1;
    c1 = t1_clr_n; c2 = t2_clr_n;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_key = 32'hBEEF; req_idx1 = 6'd3; req_idx2 = 6'd7; req_del = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_idle", 64'({req_ready, rsp_valid, hit_cnt, miss_cnt}), 64'({2'b10, 4'd0}));
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_quiet", 64'({rsp_valid, t1_clr_n - c1, t2_clr_n - c2}), 64'(0));
    end

    // Out-of-range idx1: stale table1 data matching the key must not hit
    m1_data[5] = 32'h77; m1_full[5] = 1'b1;
    m2_data[4] = 32'h77; m2_full[4] = 1'b1;
    send(32'h77, 6'd5, 6'd9, 1'b0, lat);
    chk("prime_rsp", 64'({rsp_hit, rsp_tbl, rsp_idx}), 64'({2'b10, 6'd5}));
    finish_rsp();
    r1 = t1_rd_n; r2 = t2_rd_n;
    send(32'h77, 6'd40, 6'd4, 1'b0, lat);
    chk("oor_reads", 64'({t1_rd_n - r1, t2_rd_n - r2}), {32'd0, 32'd1});
    chk("oor_rsp", 64'({rsp_valid, rsp_hit, rsp_tbl, rsp_idx}), 64'({3'b111, 6'd4}));
    finish_rsp();
    chk("oor_hit_cnt", 64'(hit_cnt), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
